vga_rx_monitor: RTL and testbench
=================================

# vga_rx_monitor

Receive-side checker for the VGA pixel stream produced by the game/display path. It samples hs, vs, VGA_BLANK and the 24-bit RGB bus on the 25 MHz pixel enable, recovers the active-pixel coordinates and measures line and frame geometry. It locks to the expected 640x480 timing and emits a per-frame RGB checksum. The block sits beside vga_controller as an on-chip self-test and bench-observable reference.

## Interface
- H_DISPLAY, 640, active pixels per line
- V_DISPLAY, 480, active lines per frame
- H_TOTAL, 800, pix_en samples per line (hs fall to hs fall)
- V_TOTAL, 525, lines per frame (vs fall to vs fall)
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..7)

Ports:
- clk_50M  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- pix_en  in  1  one-cycle strobe per pixel (every second clk_50M); all sampling is qualified by it
- hs  in  1  horizontal sync, active-low
- vs  in  1  vertical sync, active-low
- blank  in  1  VGA_BLANK convention: 1 = active video
- rgb  in  24  {R,G,B} pixel data
- rx_valid  out  1  active pixel accepted this cycle
- rx_x  out  10  active-pixel column, 0-based
- rx_y  out  10  active-line row, 0-based
- locked  out  1  geometry matches parameters for LOCK_FRAMES frames
- frame_done  out  1  one-cycle pulse at each frame boundary (not in SEARCH)
- frame_sum  out  16  checksum of the last complete frame
- err_timing  out  1  one-cycle pulse on geometry mismatch
- err_overflow  out  1  one-cycle pulse on counter saturation

## Operation
- The block registers the inputs only when pix_en=1 and holds the previous sample. An edge is detected between two consecutive qualified samples. With pix_en=0, no state changes.
- Line start: hs sample 1 followed by hs sample 0. Line length is the count of samples from that start, inclusive, to the next start, exclusive.
- Frame start: vs falling edge, detected the same way. Frame length is the number of line starts from one frame start, inclusive, to the next, exclusive.
- A line is active if at least one of its samples has blank=1. rx_x counts active samples within a line and resets at each line start. rx_y counts active lines and resets at frame start.
- Checksum: at each active sample, sum16 += R + G + B, mod 2^16. At frame start, frame_sum takes the final sum16 and sum16 clears.
- Per-line check at each line start, applied to the completed line: length != H_TOTAL, or active line with active count != H_DISPLAY, sets sticky bad_frame.
- Per-frame check at frame start: bad_frame, or lines != V_TOTAL, or active lines != V_DISPLAY, marks the frame bad.
- States:
  - SEARCH: frame_done suppressed. On frame start go to MEASURE, with match_cnt=0 and all counters cleared.
  - MEASURE: on frame start, a good frame increments match_cnt. When match_cnt reaches LOCK_FRAMES, go to LOCKED. A bad frame clears match_cnt and pulses err_timing.
  - LOCKED: a bad line at its line start, or a bad frame, pulses err_timing, drops locked, clears match_cnt and goes to MEASURE.
- Overflow: the line counter or line-count counter reaching 1023 pulses err_overflow and goes to SEARCH. Counters saturate and do not wrap.
- Simultaneous hs and vs falls in one sample: the line is closed and checked first, then the frame, so the closing line counts toward the frame.
- The first partial frame after SEARCH is never checked.

## Timing
- rx_valid, rx_x, rx_y, frame_sum, locked, frame_done and the err pulses are registered. Each updates in the clk_50M cycle after the qualifying pix_en sample (latency 1 from the sample, 2 from the input pins).
- frame_done, err_timing and err_overflow are exactly one clk_50M cycle wide.
- locked rises in the same cycle as the frame_done that completes the LOCK_FRAMES-th good frame.
- Reset values: all outputs 0, state SEARCH, sum16=0, and the sampled hs/vs treated as 1.
- Reset asserted mid-frame clears everything immediately. After release, the block waits for the next vs fall.

## Test plan
- **Nominal lock.** Stimulus: 800x525 timing with 640x480 active, rgb=24'h010203 constant, 3 frames. Required response: frame_done at 2nd and 3rd vs fall; locked=1 at the 3rd; frame_sum=16'h2000 (6×307200 mod 65536).
- **Coordinates.** Stimulus: active pixels, observed on rx_valid. Required response: rx_x runs 0..639 per line; rx_y runs 0..479; the last pixel of the frame gives rx_x=639, rx_y=479.
- **Bad geometry.** Stimulus: H_TOTAL driven as 799 throughout. Required response: locked never rises; err_timing pulses once per frame; frame_done still pulses.
- **Lock loss.** Stimulus: locked stream with a single 801-sample line. Required response: err_timing and locked=0 one cycle after that line's closing hs fall; relock after 2 further good frames.
- **Overflow.** Stimulus: hs held high for 1100 samples. Required response: err_overflow pulses once at count 1023; state SEARCH; locked=0.
- **Reset mid-frame.** Stimulus: reset low during line 200 of a locked stream. Required response: all outputs 0; no frame_done until the second vs fall after release; locked again after LOCK_FRAMES good frames.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// Receive-side checker for the VGA pixel stream: recovers active-pixel coordinates,
// measures line/frame geometry, locks to the expected timing and emits a per-frame RGB checksum.
module vga_rx_monitor #(
    parameter int H_DISPLAY   = 640,
    parameter int V_DISPLAY   = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic [23:0] rgb,
    output logic        rx_valid,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        err_timing,
    output logic        err_overflow,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam logic [9:0] CNT_MAX = 10'h3FF;

    // Sample stage: current and previous qualified samples of the syncs.
    logic        hs_s_q, hs_p_q, vs_s_q, vs_p_q, blank_s_q, smp_v_q;
    logic [23:0] rgb_s_q;

    state_e      state_q, state_d;
    logic [9:0]  h_cnt_q, h_cnt_d, x_cnt_q, x_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d, y_cnt_q, y_cnt_d;
    logic [15:0] sum_q, sum_d;
    logic        bad_q, bad_d;
    logic [2:0]  match_q, match_d;

    logic        rx_valid_q, rx_valid_d, locked_q, locked_d;
    logic        frame_done_q, frame_done_d, err_timing_q, err_timing_d;
    logic        err_overflow_q, err_overflow_d;
    logic [9:0]  rx_x_q, rx_x_d, rx_y_q, rx_y_d;
    logic [15:0] frame_sum_q, frame_sum_d;

    logic        line_start, frame_start, line_bad, frame_bad, ovf;
    logic [9:0]  h_base, x_base, v_base;
    logic [15:0] sum_base;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            hs_s_q    <= 1'b1;
            hs_p_q    <= 1'b1;
            vs_s_q    <= 1'b1;
            vs_p_q    <= 1'b1;
            blank_s_q <= 1'b0;
            rgb_s_q   <= '0;
            smp_v_q   <= 1'b0;
        end else begin
            smp_v_q <= pix_en;
            if (pix_en) begin
                hs_p_q    <= hs_s_q;
                hs_s_q    <= hs;
                vs_p_q    <= vs_s_q;
                vs_s_q    <= vs;
                blank_s_q <= blank;
                rgb_s_q   <= rgb;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        h_cnt_d        = h_cnt_q;
        x_cnt_d        = x_cnt_q;
        v_cnt_d        = v_cnt_q;
        y_cnt_d        = y_cnt_q;
        sum_d          = sum_q;
        bad_d          = bad_q;
        match_d        = match_q;
        rx_valid_d     = 1'b0;
        frame_done_d   = 1'b0;
        err_timing_d   = 1'b0;
        err_overflow_d = 1'b0;
        rx_x_d         = rx_x_q;
        rx_y_d         = rx_y_q;
        frame_sum_d    = frame_sum_q;
        locked_d       = locked_q;
        line_start     = hs_p_q & ~hs_s_q;
        frame_start    = vs_p_q & ~vs_s_q;
        line_bad       = (h_cnt_q != 10'(H_TOTAL)) ||
                         ((x_cnt_q != '0) && (x_cnt_q != 10'(H_DISPLAY)));
        frame_bad      = 1'b0;
        ovf            = 1'b0;
        h_base         = h_cnt_q;
        x_base         = x_cnt_q;
        v_base         = v_cnt_q;
        sum_base       = sum_q;

        if (smp_v_q) begin
            // The closing line is booked to the old frame before any frame check.
            if (line_start) begin
                bad_d = bad_q | line_bad;
                if (x_cnt_q != '0) y_cnt_d = sat_inc(y_cnt_q);
                if (state_q == ST_LOCKED && line_bad) begin
                    err_timing_d = 1'b1;
                    state_d      = ST_MEASURE;
                    match_d      = '0;
                end
            end
            if (frame_start) begin
                frame_bad = bad_d || (v_cnt_q != 10'(V_TOTAL)) || (y_cnt_d != 10'(V_DISPLAY));
                if (state_q == ST_SEARCH) begin
                    state_d = ST_MEASURE;
                    match_d = '0;
                end else begin
                    frame_done_d = 1'b1;
                    frame_sum_d  = sum_q;
                    if (frame_bad) begin
                        err_timing_d = 1'b1;
                        state_d      = ST_MEASURE;
                        match_d      = '0;
                    end else if (state_q == ST_MEASURE) begin
                        match_d = match_q + 3'd1;
                        if (match_d == 3'(LOCK_FRAMES)) state_d = ST_LOCKED;
                    end
                end
                bad_d    = 1'b0;
                y_cnt_d  = '0;
                v_base   = '0;
                sum_base = '0;
            end
            if (line_start) begin
                v_cnt_d = sat_inc(v_base);
                ovf     = (v_cnt_d == CNT_MAX) && (v_base != CNT_MAX);
                h_base  = '0;
                x_base  = '0;
            end else begin
                v_cnt_d = v_base;
            end
            h_cnt_d = sat_inc(h_base);
            if (h_cnt_d == CNT_MAX && h_base != CNT_MAX) ovf = 1'b1;
            x_cnt_d = blank_s_q ? sat_inc(x_base) : x_base;
            sum_d   = sum_base;
            // Pixels are only accepted once the block has seen a frame start.
            if (blank_s_q && state_q != ST_SEARCH) begin
                rx_valid_d = 1'b1;
                rx_x_d     = x_base;
                rx_y_d     = y_cnt_d;
                sum_d      = sum_base + 16'(rgb_s_q[23:16]) + 16'(rgb_s_q[15:8]) + 16'(rgb_s_q[7:0]);
            end
            if (ovf) begin
                err_overflow_d = 1'b1;
                state_d        = ST_SEARCH;
                match_d        = '0;
            end
            locked_d = (state_d == ST_LOCKED);
        end
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_SEARCH;
            h_cnt_q        <= '0;
            x_cnt_q        <= '0;
            v_cnt_q        <= '0;
            y_cnt_q        <= '0;
            sum_q          <= '0;
            bad_q          <= 1'b0;
            match_q        <= '0;
            rx_valid_q     <= 1'b0;
            rx_x_q         <= '0;
            rx_y_q         <= '0;
            locked_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_sum_q    <= '0;
            err_timing_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_cnt_q        <= h_cnt_d;
            x_cnt_q        <= x_cnt_d;
            v_cnt_q        <= v_cnt_d;
            y_cnt_q        <= y_cnt_d;
            sum_q          <= sum_d;
            bad_q          <= bad_d;
            match_q        <= match_d;
            rx_valid_q     <= rx_valid_d;
            rx_x_q         <= rx_x_d;
            rx_y_q         <= rx_y_d;
            locked_q       <= locked_d;
            frame_done_q   <= frame_done_d;
            frame_sum_q    <= frame_sum_d;
            err_timing_q   <= err_timing_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign rx_valid     = rx_valid_q;
    assign rx_x         = rx_x_q;
    assign rx_y         = rx_y_q;
    assign locked       = locked_q;
    assign frame_done   = frame_done_q;
    assign frame_sum    = frame_sum_q;
    assign err_timing   = err_timing_q;
    assign err_overflow = err_overflow_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a reduced 20x12 geometry (12x8 active); a sample-level reference
// model predicts every output event and a negedge monitor compares them in order.
module tb_vga_rx_monitor;
    localparam int H_DISPLAY   = 12;
    localparam int V_DISPLAY   = 8;
    localparam int H_TOTAL     = 20;
    localparam int V_TOTAL     = 12;
    localparam int LOCK_FRAMES = 2;
    localparam int W           = 41;

    logic        clk_50M = 1'b0;
    logic        reset;
    logic        pix_en, hs, vs, blank;
    logic [23:0] rgb;
    logic        rx_valid, locked, frame_done, err_timing, err_overflow;
    logic [9:0]  rx_x, rx_y;
    logic [15:0] frame_sum;
    logic [1:0]  state_dbg;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act, mon_exp;

    always #10 clk_50M = ~clk_50M;

    vga_rx_monitor #(
        .H_DISPLAY(H_DISPLAY), .V_DISPLAY(V_DISPLAY), .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk_50M(clk_50M), .reset(reset), .pix_en(pix_en), .hs(hs), .vs(vs),
        .blank(blank), .rgb(rgb), .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y),
        .locked(locked), .frame_done(frame_done), .frame_sum(frame_sum),
        .err_timing(err_timing), .err_overflow(err_overflow), .state_dbg(state_dbg)
    );

    // Reference model state: plain unbounded counts derived from the stream rules.
    bit m_prev_hs, m_prev_vs, m_sync, m_lk, m_bad;
    int m_len, m_act, m_lines, m_alines, m_sum, m_run, m_x, m_y, m_fsum;

    task automatic model_reset();
        m_prev_hs = 1; m_prev_vs = 1; m_sync = 0; m_lk = 0; m_bad = 0;
        m_len = 0; m_act = 0; m_lines = 0; m_alines = 0; m_sum = 0;
        m_run = 0; m_x = 0; m_y = 0; m_fsum = 0;
    endtask

    task automatic model_step(input bit h, input bit v, input bit b, input logic [23:0] c);
        bit hf, vf, sync0, rv, fd, et, ov, ok;
        hf = m_prev_hs && !h;
        vf = m_prev_vs && !v;
        sync0 = m_sync;
        rv = 0; fd = 0; et = 0; ov = 0;
        if (hf) begin
            ok = (m_len == H_TOTAL) && (m_act == 0 || m_act == H_DISPLAY);
            if (m_act > 0) m_alines++;
            if (!ok) begin
                m_bad = 1;
                if (m_lk) begin et = 1; m_lk = 0; m_run = 0; end
            end
        end
        if (vf) begin
            if (m_sync) begin
                fd = 1;
                m_fsum = m_sum;
                if (!m_bad && m_lines == V_TOTAL && m_alines == V_DISPLAY) begin
                    m_run++;
                    if (m_run >= LOCK_FRAMES) m_lk = 1;
                end else begin
                    et = 1; m_lk = 0; m_run = 0;
                end
            end else begin
                m_sync = 1; m_run = 0;
            end
            m_sum = 0; m_bad = 0; m_lines = 0; m_alines = 0;
        end
        if (hf) begin
            m_lines++; m_len = 0; m_act = 0;
            if (m_lines == 1023) ov = 1;
        end
        m_len++;
        if (m_len == 1023) ov = 1;
        if (b) begin
            if (sync0) begin
                rv = 1; m_x = m_act; m_y = m_alines;
                m_sum = (m_sum + int'(c[23:16]) + int'(c[15:8]) + int'(c[7:0])) % 65536;
            end
            m_act++;
        end
        if (ov) begin m_sync = 0; m_lk = 0; m_run = 0; end
        m_prev_hs = h;
        m_prev_vs = v;
        if (rv || fd || et || ov)
            exp_q.push_back({rv, fd, et, ov, m_lk, 10'(m_x), 10'(m_y), 16'(m_fsum)});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_sample(input bit h, input bit v, input bit b, input logic [23:0] c);
        @(negedge clk_50M);
        hs = h; vs = v; blank = b; rgb = c; pix_en = 1'b1;
        model_step(h, v, b, c);
        @(negedge clk_50M);
        pix_en = 1'b0;
    endtask

    // Lines start with hs low for 3 samples; vs low on lines 0-1; active window at p 4.., l 2..
    task automatic send_lines(input int htot, input int l0, input int l1,
                              input int bad_line, input int bad_len, input bit rnd);
        for (int l = l0; l <= l1; l++) begin
            int len;
            len = (l == bad_line) ? bad_len : htot;
            for (int p = 0; p < len; p++) begin
                logic [23:0] c;
                c = rnd ? 24'($urandom) : 24'h010203;
                send_sample(p >= 3, l >= 2,
                            (l >= 2) && (l < 2 + V_DISPLAY) && (p >= 4) && (p < 4 + H_DISPLAY), c);
            end
        end
    endtask

    task automatic send_frames(input int n, input int htot, input bit rnd);
        for (int f = 0; f < n; f++) send_lines(htot, 0, V_TOTAL - 1, -1, 0, rnd);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk_50M);
    endtask

    always @(negedge clk_50M) begin
        if (reset === 1'b1 && (rx_valid || frame_done || err_timing || err_overflow)) begin
            mon_act = {rx_valid, frame_done, err_timing, err_overflow, locked, rx_x, rx_y, frame_sum};
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_record: got %0h, expected no output event", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL out_record: got %0h, expected %0h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; rgb = '0;
        model_reset();
        repeat (3) @(negedge clk_50M);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_x", rx_x, 0);
        check("rst_rx_y", rx_y, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_sum", frame_sum, 0);
        check("rst_err_timing", err_timing, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;

        // Nominal lock with constant colour: 96 pixels * 6 = 16'h0240.
        send_frames(3, H_TOTAL, 1'b0);
        settle();
        check("nominal_locked", locked, 1);
        check("nominal_frame_sum", frame_sum, 16'h0240);

        // Coordinates and checksum with random colour.
        send_frames(2, H_TOTAL, 1'b1);

        // Lock loss on a single over-long line, then relock.
        send_lines(H_TOTAL, 0, V_TOTAL - 1, 5, H_TOTAL + 1, 1'b1);
        send_frames(3, H_TOTAL, 1'b1);
        settle();
        check("relock_locked", locked, 1);

        // Short lines throughout: never locks.
        send_frames(4, H_TOTAL - 1, 1'b1);
        settle();
        check("bad_geom_locked", locked, 0);
        send_frames(3, H_TOTAL, 1'b1);

        // Overflow: hs held high.
        for (int i = 0; i < 1100; i++) send_sample(1'b1, 1'b1, 1'b0, 24'h0);
        settle();
        check("ovf_state", state_dbg, 0);
        check("ovf_locked", locked, 0);

        // Relock, then reset in the middle of a frame.
        send_frames(3, H_TOTAL, 1'b1);
        send_lines(H_TOTAL, 0, 5, -1, 0, 1'b1);
        settle();
        reset = 1'b0;
        model_reset();
        @(negedge clk_50M);
        check("midrst_locked", locked, 0);
        check("midrst_frame_sum", frame_sum, 0);
        check("midrst_rx_x", rx_x, 0);
        check("midrst_rx_y", rx_y, 0);
        check("midrst_state", state_dbg, 0);
        reset = 1'b1;
        send_lines(H_TOTAL, 6, V_TOTAL - 1, -1, 0, 1'b1);
        send_frames(3, H_TOTAL, 1'b1);
        settle();
        check("final_locked", locked, 1);
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
